hub75_fb_readout: RTL and testbench

//  Frame-buffer read-out engine: counterpart of the write-in path. On request it arbitrates for the

---
 rtl/hub75_fb_readout_pkg.sv | 23 ++
 rtl/hub75_fb_readout_if.sv | 25 ++
 rtl/hub75_fb_readout_linebuffer.sv | 38 +++
 rtl/hub75_fb_readout.sv | 182 ++++++++++++++++++
 tb/tb_hub75_fb_readout.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/hub75_fb_readout_pkg.sv
// Shared definitions for the HUB75 frame-buffer read-out path: fill FSM
// states and the width helpers used for the FB address layout
// {row, col, bank, dc_idx}.
package hub75_fb_readout_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PEND,
    ST_RUN,
    ST_DRAIN
  } fill_state_t;

  // Number of dc_idx bits in an FB address; zero when a pixel is one word.
  function automatic int cs_width(input int fb_dc);
    return (fb_dc > 1) ? $clog2(fb_dc) : 0;
  endfunction

  // Width of the fill counter {col, dc_idx}.
  function automatic int cw_width(input int n_cols, input int fb_dc);
    return $clog2(n_cols) + cs_width(fb_dc);
  endfunction

endpackage

// File: rtl/hub75_fb_readout_if.sv
// Frame-buffer side of the read-out engine: arbiter handshake plus the
// FB read bus. The read-out engine is the master.
interface hub75_fb_readout_if #(
  parameter int FB_AW = 13,
  parameter int FB_DW = 16
) ();

  logic             ctrl_req;
  logic             ctrl_gnt;
  logic             ctrl_rel;
  logic [FB_AW-1:0] fb_addr;
  logic             fb_rden;
  logic [FB_DW-1:0] fb_data;

  modport master (
    output ctrl_req, ctrl_rel, fb_addr, fb_rden,
    input  ctrl_gnt, fb_data
  );

  modport slave (
    input  ctrl_req, ctrl_rel, fb_addr, fb_rden,
    output ctrl_gnt, fb_data
  );

endinterface

// File: rtl/hub75_fb_readout_linebuffer.sv
// Simple dual-port line buffer: one write port with per-word mask and one
// registered read port. Contents are not reset.
module hub75_linebuffer #(
  parameter int N_WORDS    = 1,
  parameter int WORD_WIDTH = 24,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                          clk,
  input  logic [ADDR_WIDTH-1:0]         wr_addr,
  input  logic [N_WORDS*WORD_WIDTH-1:0] wr_data,
  input  logic [N_WORDS-1:0]            wr_mask,
  input  logic                          wr_en,
  input  logic [ADDR_WIDTH-1:0]         rd_addr,
  input  logic                          rd_en,
  output logic [N_WORDS*WORD_WIDTH-1:0] rd_data
);

  logic [N_WORDS*WORD_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Write the enabled words of the addressed entry
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int w = 0; w < N_WORDS; w++) begin
        if (wr_mask[w]) begin
          mem[wr_addr][w*WORD_WIDTH +: WORD_WIDTH] <= wr_data[w*WORD_WIDTH +: WORD_WIDTH];
        end
      end
    end
  end

  // Registered read: data appears the cycle after rd_en
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/hub75_fb_readout.sv
// Frame-buffer read-out engine. On rd_row_load it requests the shared FB,
// streams one bank/row out of it, reassembles FB_DC words per pixel and
// fills the back half of a double line buffer; the scan side reads pixels
// from the front half at any time.
module hub75_fb_readout
  import hub75_fb_readout_pkg::*;
#(
  parameter int N_BANKS  = 2,
  parameter int N_ROWS   = 32,
  parameter int N_COLS   = 64,
  parameter int BITDEPTH = 24,
  parameter int FB_AW    = 13,
  parameter int FB_DW    = 16,
  parameter int FB_DC    = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [$clog2(N_BANKS)-1:0]  rd_bank_addr,
  input  logic [$clog2(N_ROWS)-1:0]   rd_row_addr,
  input  logic                        rd_row_load,
  output logic                        rd_row_rdy,
  input  logic                        rd_row_swap,
  input  logic [$clog2(N_COLS)-1:0]   rd_col_addr,
  input  logic                        rd_en,
  output logic [BITDEPTH-1:0]         rd_data,
  hub75_fb_readout_if.master          fb
);

  localparam int LOG_N_BANKS = $clog2(N_BANKS);
  localparam int LOG_N_ROWS  = $clog2(N_ROWS);
  localparam int LOG_N_COLS  = $clog2(N_COLS);
  localparam int CS          = cs_width(FB_DC);
  localparam int CW          = cw_width(N_COLS, FB_DC);
  localparam int LAST_CNT    = N_COLS * FB_DC - 1;
  localparam int PW          = FB_DW * FB_DC;

  fill_state_t            state;
  fill_state_t            state_nxt;
  logic [LOG_N_BANKS-1:0] bank_q;
  logic [LOG_N_ROWS-1:0]  row_q;
  logic [CW-1:0]          cnt;
  logic                   run_last;
  logic                   sel;
  logic                   rel_q;
  logic                   rden_q;
  logic [CW-1:0]          cnt_q;
  logic [LOG_N_COLS-1:0]  col_q;
  logic [PW-1:0]          pixel_word;
  logic                   word_last;
  logic [FB_AW-1:0]       addr_raw;

  assign run_last    = (cnt == CW'(LAST_CNT));
  assign col_q       = cnt_q[CW-1 -: LOG_N_COLS];
  assign fb.ctrl_rel = rel_q;
  assign fb.fb_addr  = fb.fb_rden ? addr_raw : '0;

  // Fill FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Fill FSM next state and handshake outputs; DRAIN covers the last data return
  always_comb begin
    state_nxt   = state;
    rd_row_rdy  = 1'b0;
    fb.ctrl_req = 1'b0;
    fb.fb_rden  = 1'b0;
    case (state)
      ST_IDLE: begin
        rd_row_rdy = 1'b1;
        if (rd_row_load) begin
          state_nxt = ST_PEND;
        end
      end
      ST_PEND: begin
        fb.ctrl_req = 1'b1;
        if (fb.ctrl_gnt) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        fb.fb_rden = 1'b1;
        if (run_last) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Latch the requested bank/row on an accepted load and step the fill counter
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_q <= '0;
      row_q  <= '0;
      cnt    <= '0;
    end else begin
      if (state == ST_IDLE && rd_row_load) begin
        bank_q <= rd_bank_addr;
        row_q  <= rd_row_addr;
      end
      if (state == ST_RUN) begin
        cnt <= run_last ? '0 : cnt + 1'b1;
      end
    end
  end

  // Buffer select toggles on swap; release pulses the cycle after the last write
  always_ff @(posedge clk) begin
    if (rst) begin
      sel   <= 1'b0;
      rel_q <= 1'b0;
    end else begin
      if (rd_row_swap) begin
        sel <= ~sel;
      end
      rel_q <= (state == ST_DRAIN);
    end
  end

  // Track which counter value the returning FB word belongs to
  always_ff @(posedge clk) begin
    if (rst) begin
      rden_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      rden_q <= fb.fb_rden;
      cnt_q  <= cnt;
    end
  end

  if (CS > 0) begin : g_multi_word
    logic [CS-1:0]             dc_q;
    logic [PW-FB_DW-1:0]       hold;

    assign dc_q       = cnt_q[CS-1:0];
    assign word_last  = (dc_q == CS'(FB_DC - 1));
    assign pixel_word = {fb.fb_data, hold};
    assign addr_raw   = {row_q, cnt[CW-1 -: LOG_N_COLS], bank_q, cnt[CS-1:0]};

    // Park the lower words of a pixel until its top word returns
    always_ff @(posedge clk) begin
      if (rden_q && !word_last) begin
        hold[int'(dc_q)*FB_DW +: FB_DW] <= fb.fb_data;
      end
    end
  end else begin : g_single_word
    assign word_last  = 1'b1;
    assign pixel_word = fb.fb_data;
    assign addr_raw   = {row_q, cnt, bank_q};
  end

  if (PW > BITDEPTH) begin : g_trunc
    logic unused_pixel_bits;
    assign unused_pixel_bits = ^pixel_word[PW-1:BITDEPTH];
  end

  hub75_linebuffer #(
    .N_WORDS    (1),
    .WORD_WIDTH (BITDEPTH),
    .ADDR_WIDTH (1 + LOG_N_COLS)
  ) u_linebuffer (
    .clk     (clk),
    .wr_addr ({~sel, col_q}),
    .wr_data (pixel_word[BITDEPTH-1:0]),
    .wr_mask (1'b1),
    .wr_en   (rden_q && word_last),
    .rd_addr ({sel, rd_col_addr}),
    .rd_en   (rd_en),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_hub75_fb_readout.sv
// Scoreboard bench for hub75_fb_readout. Stimulus pushes expected FB
// addresses, release cycles and pixels into queues; a negedge monitor pops
// and compares them whenever the DUT presents fb_rden, ctrl_rel or rd_data.
module tb_hub75_fb_readout;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [0:0]  rd_bank_addr;
  logic [4:0]  rd_row_addr;
  logic        rd_row_load;
  logic        rd_row_rdy;
  logic        rd_row_swap;
  logic [5:0]  rd_col_addr;
  logic        rd_en;
  logic [23:0] rd_data;

  hub75_fb_readout_if #(.FB_AW(13), .FB_DW(16)) fb ();

  hub75_fb_readout #(
    .N_BANKS(2), .N_ROWS(32), .N_COLS(64), .BITDEPTH(24),
    .FB_AW(13), .FB_DW(16), .FB_DC(2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rd_bank_addr (rd_bank_addr),
    .rd_row_addr  (rd_row_addr),
    .rd_row_load  (rd_row_load),
    .rd_row_rdy   (rd_row_rdy),
    .rd_row_swap  (rd_row_swap),
    .rd_col_addr  (rd_col_addr),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .fb           (fb)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // FB model: one cycle latency, word = {addr, 3'b0}
  always @(posedge clk) begin
    if (fb.fb_rden) fb.fb_data <= {fb.fb_addr, 3'b000};
    else            fb.fb_data <= 16'hDEAD;
  end

  int tests_run = 0;
  int tests_failed = 0;

  logic [12:0] exp_addr[$];
  logic [23:0] exp_pix[$];
  int          exp_rel[$];

  bit mon_en = 1'b0;
  bit rd_pend = 1'b0;
  bit req_prev = 1'b0;
  int req_rises = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic logic [12:0] addr_of(input int bank, input int row, input int col, input int dc);
    return {5'(row), 6'(col), 1'(bank), 1'(dc)};
  endfunction

  function automatic logic [23:0] pixel_of(input int bank, input int row, input int col);
    logic [31:0] full;
    full = {addr_of(bank, row, col, 1), 3'b000, addr_of(bank, row, col, 0), 3'b000};
    return full[23:0];
  endfunction

  // Monitor: compare every DUT output event against the scoreboard queues
  always @(negedge clk) begin
    if (mon_en) begin
      if (rd_pend && exp_pix.size() > 0) begin
        logic [23:0] e;
        e = exp_pix.pop_front();
        checkOutput("rd_data", rd_data, e);
      end
      rd_pend = rd_en;
      if (fb.fb_rden) begin
        if (exp_addr.size() == 0) begin
          checkOutput("fb_rden_unexpected", fb.fb_rden, 0);
        end else begin
          logic [12:0] a;
          a = exp_addr.pop_front();
          checkOutput("fb_addr", fb.fb_addr, a);
        end
      end
      if (fb.ctrl_rel) begin
        if (exp_rel.size() == 0) begin
          checkOutput("ctrl_rel_unexpected", fb.ctrl_rel, 0);
        end else begin
          int c;
          c = exp_rel.pop_front();
          checkOutput("ctrl_rel_cycle", cyc, c);
          checkOutput("rdy_with_rel", rd_row_rdy, 1);
        end
      end
      if (rd_row_swap) checkOutput("swap_only_when_rdy", rd_row_rdy, 1);
      if (fb.ctrl_req && !req_prev) req_rises++;
      req_prev = fb.ctrl_req;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One cycle of inputs, applied just after the rising edge
  task automatic applyStimulus(input logic load, input logic swap, input logic gnt, input logic ren,
                               input int bank, input int row, input int col);
    step();
    rd_row_load  = load;
    rd_row_swap  = swap;
    fb.ctrl_gnt  = gnt;
    rd_en        = ren;
    rd_bank_addr = 1'(bank);
    rd_row_addr  = 5'(row);
    rd_col_addr  = 6'(col);
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic swap();
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
  endtask

  task automatic read_px(input int col, input logic [23:0] expected);
    exp_pix.push_back(expected);
    applyStimulus(0, 0, 0, 1, 0, 0, col);
  endtask

  task automatic push_addrs(input int bank, input int row, input int n);
    for (int i = 0; i < n; i++) exp_addr.push_back(addr_of(bank, row, i / 2, i % 2));
  endtask

  // Load, wait two cycles in PEND, then grant; returns the grant cycle
  task automatic start_fill(input int bank, input int row, input logic swp, input int n_addr,
                            input bit want_rel, output int gnt_cyc);
    push_addrs(bank, row, n_addr);
    applyStimulus(1, swp, 0, 0, bank, row, 0);
    idle();
    checkOutput("rdy_busy", rd_row_rdy, 0);
    checkOutput("req_pend", fb.ctrl_req, 1);
    idle();
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    gnt_cyc = cyc;
    if (want_rel) exp_rel.push_back(gnt_cyc + 130);
  endtask

  task automatic wait_done(input int budget);
    int i;
    i = 0;
    while (i < budget && !rd_row_rdy) begin
      idle();
      i++;
    end
    checkOutput("fill_done_rdy", rd_row_rdy, 1);
    checkOutput("addr_queue_drained", exp_addr.size(), 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int g;
    int r0;
    rd_bank_addr = '0; rd_row_addr = '0; rd_row_load = 0; rd_row_swap = 0;
    rd_col_addr = '0; rd_en = 0; fb.ctrl_gnt = 0;
    rst = 1'b1;
    repeat (3) idle();
    rst = 1'b0;
    mon_en = 1'b1;

    // 1: idle after reset
    for (int i = 0; i < 10; i++) begin
      idle();
      checkOutput("idle_rdy", rd_row_rdy, 1);
      checkOutput("idle_req", fb.ctrl_req, 0);
      checkOutput("idle_rden", fb.fb_rden, 0);
      checkOutput("idle_rel", fb.ctrl_rel, 0);
    end

    // 2: fill bank 1 row 5
    start_fill(1, 5, 0, 128, 1, g);
    idle();
    checkOutput("req_drop_after_gnt", fb.ctrl_req, 0);
    wait_done(300);

    // 3: swap and read back, hand-computed pixels
    swap();
    read_px(7, 24'hF828F0);
    read_px(0, 24'h182810);
    read_px(63, 24'hF82FF0);
    idle();

    // 4: fill B, then swap+load C while reading B from the front
    start_fill(0, 12, 0, 128, 1, g);
    wait_done(300);
    start_fill(0, 31, 1, 128, 1, g);
    read_px(0, pixel_of(0, 12, 0));
    read_px(7, pixel_of(0, 12, 7));
    repeat (20) idle();
    read_px(40, pixel_of(0, 12, 40));
    repeat (60) idle();
    read_px(63, pixel_of(0, 12, 63));
    wait_done(300);
    read_px(40, pixel_of(0, 12, 40));
    swap();
    read_px(63, 24'hE8FFE0);
    read_px(20, pixel_of(0, 31, 20));
    idle();

    // 5: load while busy and grants outside PEND are ignored
    r0 = req_rises;
    push_addrs(1, 9, 128);
    applyStimulus(1, 0, 0, 0, 1, 9, 0);
    applyStimulus(1, 0, 0, 0, 0, 2, 0);
    idle();
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    exp_rel.push_back(cyc + 130);
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 17, 0);
    wait_done(300);
    checkOutput("req_once_per_fill", req_rises - r0, 1);
    r0 = req_rises;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 1, 0, 0, 0, 0);
      idle();
      checkOutput("idle_gnt_req", fb.ctrl_req, 0);
      checkOutput("idle_gnt_rden", fb.fb_rden, 0);
      checkOutput("idle_gnt_rdy", rd_row_rdy, 1);
    end
    checkOutput("idle_gnt_no_req", req_rises - r0, 0);
    swap();
    read_px(10, pixel_of(1, 9, 10));
    read_px(33, pixel_of(1, 9, 33));
    idle();

    // 6: reset in RUN cycle 40, then a clean fill
    start_fill(0, 3, 0, 40, 0, g);
    repeat (39) idle();
    idle();
    rst = 1'b1;
    idle();
    rst = 1'b0;
    checkOutput("rst_rden", fb.fb_rden, 0);
    checkOutput("rst_req", fb.ctrl_req, 0);
    checkOutput("rst_rdy", rd_row_rdy, 1);
    checkOutput("rst_rel", fb.ctrl_rel, 0);
    repeat (140) idle();
    checkOutput("rst_addr_queue", exp_addr.size(), 0);
    start_fill(1, 30, 0, 128, 1, g);
    wait_done(300);
    swap();
    read_px(63, 24'hF8F7F0);
    read_px(0, pixel_of(1, 30, 0));
    repeat (3) idle();

    checkOutput("pix_queue_drained", exp_pix.size(), 0);
    checkOutput("rel_queue_drained", exp_rel.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
